// File: rtl/hdmi_i2c_config.sv
// I2C master that writes the HDMI transmitter's init register table after reset and again on
// every hot-plug interrupt; config_done marks when the video stream is accepted.
module hdmi_i2c_config #(
   parameter int unsigned CLK_FREQ_HZ       = 50000000,
   parameter int unsigned I2C_FREQ_HZ       = 100000,
   parameter logic [6:0]  DEV_ADDR          = 7'h39,
   parameter int unsigned POWER_WAIT_CYCLES = 10000000,
   parameter int unsigned RETRY_CYCLES      = 50000
) (
   input  logic clock_50,
   input  logic reset,
   input  logic hdmi_tx_int,
   output logic i2c_scl,
   inout  wire  i2c_sda,
   output logic busy,
   output logic config_done,
   output logic ack_error
);

   localparam int unsigned QpRaw   = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
   localparam int unsigned Qp      = (QpRaw < 1) ? 1 : QpRaw;
   localparam int unsigned DivW    = (Qp > 1) ? $clog2(Qp) : 1;
   localparam int unsigned WaitMax = (POWER_WAIT_CYCLES > RETRY_CYCLES) ? POWER_WAIT_CYCLES
                                                                         : RETRY_CYCLES;
   localparam int unsigned WaitW   = $clog2(WaitMax + 1);

   typedef enum logic [2:0] {
      StPowerWait, StStart, StTxByte, StAck, StStop, StGap, StRetryWait, StDone
   } state_e;

   state_e            state_q, state_d;
   logic [DivW-1:0]   div_q, div_d;
   logic [1:0]        qtr_q, qtr_d;
   logic [2:0]        bit_q, bit_d;
   logic [1:0]        byte_q, byte_d;
   logic [3:0]        idx_q, idx_d;
   logic [WaitW-1:0]  wait_q, wait_d;
   logic [7:0]        shift_q, shift_d;
   logic              nack_q, nack_d;
   logic              ack_error_q, ack_error_d;
   logic [1:0]        int_sync_q;
   logic              int_prev_q;
   logic              int_pending_q, int_pending_d;
   logic              tick, int_fall, start_txn, sda_low;

   function automatic logic [15:0] table_entry(input logic [3:0] idx);
      case (idx)
         4'd0:    return 16'h4110;
         4'd1:    return 16'h9803;
         4'd2:    return 16'h9AE0;
         4'd3:    return 16'h9C30;
         4'd4:    return 16'h9D61;
         4'd5:    return 16'hA2A4;
         4'd6:    return 16'hA3A4;
         4'd7:    return 16'hE0D0;
         4'd8:    return 16'hF900;
         4'd9:    return 16'h1500;
         4'd10:   return 16'h1630;
         4'd11:   return 16'hAF16;
         default: return 16'h0000;
      endcase
   endfunction

   // Byte 0 is the write address, 1 the register, 2 the value.
   function automatic logic [7:0] byte_of(input logic [3:0] idx, input logic [1:0] sel);
      logic [15:0] entry;
      entry = table_entry(idx);
      case (sel)
         2'd0:    return {DEV_ADDR, 1'b0};
         2'd1:    return entry[15:8];
         default: return entry[7:0];
      endcase
   endfunction

   assign tick     = (div_q == DivW'(Qp - 1));
   assign int_fall = int_prev_q & ~int_sync_q[1];

   always_comb begin
      state_d       = state_q;
      div_d         = tick ? '0 : div_q + DivW'(1);
      qtr_d         = tick ? qtr_q + 2'd1 : qtr_q;
      bit_d         = bit_q;
      byte_d        = byte_q;
      idx_d         = idx_q;
      wait_d        = wait_q;
      shift_d       = shift_q;
      nack_d        = nack_q;
      ack_error_d   = ack_error_q;
      int_pending_d = int_pending_q | int_fall;
      start_txn     = 1'b0;

      case (state_q)
         StPowerWait: begin
            if (wait_q == WaitW'(POWER_WAIT_CYCLES - 1)) begin
               wait_d    = '0;
               start_txn = 1'b1;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StStart: begin
            if (tick && qtr_q == 2'd3) begin
               state_d = StTxByte;
               bit_d   = 3'd0;
               byte_d  = 2'd0;
               shift_d = byte_of(idx_q, 2'd0);
            end
         end
         StTxByte: begin
            if (tick && qtr_q == 2'd3) begin
               if (bit_q == 3'd7) begin
                  state_d = StAck;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {shift_q[6:0], 1'b0};
               end
            end
         end
         StAck: begin
            if (tick && qtr_q == 2'd1 && i2c_sda) nack_d = 1'b1;
            if (tick && qtr_q == 2'd3) begin
               if (nack_q || byte_q == 2'd2) begin
                  state_d = StStop;
               end else begin
                  state_d = StTxByte;
                  byte_d  = byte_q + 2'd1;
                  bit_d   = 3'd0;
                  shift_d = byte_of(idx_q, byte_q + 2'd1);
               end
            end
         end
         StStop: begin
            if (tick && qtr_q == 2'd3) state_d = StGap;
         end
         StGap: begin
            if (tick && qtr_q == 2'd3) begin
               if (nack_q) begin
                  ack_error_d = 1'b1;
                  idx_d       = 4'd0;
                  wait_d      = '0;
                  state_d     = StRetryWait;
               end else if (idx_q == 4'd11) begin
                  ack_error_d = 1'b0;
                  state_d     = StDone;
               end else begin
                  idx_d     = idx_q + 4'd1;
                  start_txn = 1'b1;
               end
            end
         end
         StRetryWait: begin
            if (wait_q == WaitW'(RETRY_CYCLES - 1)) begin
               wait_d    = '0;
               start_txn = 1'b1;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StDone: begin
            // A fresh edge on the exit cycle survives when an older one is being consumed.
            if (int_pending_q || int_fall) begin
               idx_d         = 4'd0;
               start_txn     = 1'b1;
               int_pending_d = int_pending_q & int_fall;
            end
         end
         default: state_d = StPowerWait;
      endcase

      if (start_txn) begin
         state_d = StStart;
         div_d   = '0;
         qtr_d   = 2'd0;
         nack_d  = 1'b0;
      end
   end

   always_ff @(posedge clock_50) begin
      if (reset) begin
         state_q       <= StPowerWait;
         div_q         <= '0;
         qtr_q         <= 2'd0;
         bit_q         <= 3'd0;
         byte_q        <= 2'd0;
         idx_q         <= 4'd0;
         wait_q        <= '0;
         shift_q       <= 8'h00;
         nack_q        <= 1'b0;
         ack_error_q   <= 1'b0;
         int_sync_q    <= 2'b11;
         int_prev_q    <= 1'b1;
         int_pending_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         qtr_q         <= qtr_d;
         bit_q         <= bit_d;
         byte_q        <= byte_d;
         idx_q         <= idx_d;
         wait_q        <= wait_d;
         shift_q       <= shift_d;
         nack_q        <= nack_d;
         ack_error_q   <= ack_error_d;
         int_sync_q    <= {int_sync_q[0], hdmi_tx_int};
         int_prev_q    <= int_sync_q[1];
         int_pending_q <= int_pending_d;
      end
   end

   // Quarter shapes: START and STOP move SDA while SCL is high, data bits never do.
   always_comb begin
      i2c_scl = 1'b1;
      sda_low = 1'b0;
      unique case (state_q)
         StStart: begin
            i2c_scl = (qtr_q != 2'd3);
            sda_low = qtr_q[1];
         end
         StTxByte: begin
            i2c_scl = qtr_q[0] ^ qtr_q[1];
            sda_low = ~shift_q[7];
         end
         StAck:   i2c_scl = qtr_q[0] ^ qtr_q[1];
         StStop: begin
            i2c_scl = (qtr_q != 2'd0);
            sda_low = (qtr_q != 2'd3);
         end
         default: ;
      endcase
   end

   assign i2c_sda     = sda_low ? 1'b0 : 1'bz;
   assign busy        = (state_q != StDone);
   assign config_done = (state_q == StDone);
   assign ack_error   = ack_error_q;

endmodule
